// File: rtl/fp_div_nr.sv
// Iterative IEEE-style floating-point divider: Newton-Raphson reciprocal, then an
// exact remainder correction so the round-to-nearest-even result is exact.
module fp_div_nr #(
  parameter int EXP_W      = 8,
  parameter int FRAC_W     = 23,
  parameter int ITERATIONS = 3,
  localparam int W         = 1 + EXP_W + FRAC_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         data_valid_i,
  output logic         ready_o,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic         data_valid_o,
  input  logic         data_ready_i,
  output logic [W-1:0] z_o,
  output logic         except_invalid_operation_o,
  output logic         except_div_by_zero_o,
  output logic         except_overflow_o,
  output logic         except_underflow_o
);
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int MW   = FRAC_W + 1;   // significand with hidden bit
  localparam int P    = FRAC_W + 8;   // reciprocal fraction bits
  localparam int XW   = P + 2;
  localparam int NW   = MW + 1;
  localparam int QW   = MW + 2;
  localparam int EW   = EXP_W + 2;
  localparam int RW   = 2*MW + 4;
  localparam int IW   = $clog2(ITERATIONS + 1) + 1;

  localparam logic [XW-1:0] C48 = XW'((64'd48 << P) / 64'd17);
  localparam logic [XW-1:0] C32 = XW'((64'd32 << P) / 64'd17);
  localparam logic [XW-1:0] TWO = XW'(64'd2 << P);
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);

  if (4*(2**ITERATIONS) < FRAC_W + 3 || EXP_W < 3) begin : g_bad_params
    $error("fp_div_nr: ITERATIONS too small for FRAC_W, or EXP_W < 3");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_SPECIAL, S_SEED, S_ITER_T, S_ITER_X, S_QUOT, S_REM, S_ROUND, S_DONE
  } state_e;

  typedef enum logic [1:0] {K_NAN, K_DBZ, K_ZERO, K_INF} kind_e;

  state_e                 state_q, state_d;
  kind_e                  kind_q, kind_d;
  logic [IW-1:0]          it_q, it_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [NW-1:0]          n_q, n_d;
  logic [MW-1:0]          my_q, my_d;
  logic [XW-1:0]          x_q, x_d, t_q, t_d;
  logic [QW-1:0]          q_q, q_d;
  logic                   sticky_q, sticky_d;
  logic [W-1:0]           z_q, z_d;
  logic                   inv_q, inv_d, dbz_q, dbz_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                   vld_q, vld_d;

  // operand classification (exp==0 flushes to zero)
  logic [EXP_W-1:0]  xe, ye;
  logic [FRAC_W-1:0] xf, yf;
  logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, lt;
  logic [MW-1:0] mx_w, my_w;

  always_comb begin
    xe     = x_i[W-2 -: EXP_W];
    ye     = y_i[W-2 -: EXP_W];
    xf     = x_i[FRAC_W-1:0];
    yf     = y_i[FRAC_W-1:0];
    x_zero = (xe == '0);
    y_zero = (ye == '0);
    x_inf  = (xe == '1) && (xf == '0);
    y_inf  = (ye == '1) && (yf == '0);
    x_nan  = (xe == '1) && (xf != '0);
    y_nan  = (ye == '1) && (yf != '0);
    mx_w   = {1'b1, xf};
    my_w   = {1'b1, yf};
    lt     = (mx_w < my_w);
  end

  logic [P-1:0]          d_w;
  logic [P+XW-1:0]       seed_prod, t_prod;
  logic [2*XW-1:0]       x_prod;
  logic [NW+XW-1:0]      q_prod;
  logic signed [RW-1:0]  rem, rem_adj;
  logic [MW-1:0]         mant;
  logic [MW:0]           mant_r;
  logic                  rnd_up;
  logic signed [EW-1:0]  exp_f;

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    it_d     = it_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    n_d      = n_q;
    my_d     = my_q;
    x_d      = x_q;
    t_d      = t_q;
    q_d      = q_q;
    sticky_d = sticky_q;
    z_d      = z_q;
    inv_d    = inv_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    vld_d    = vld_q;

    d_w       = {my_q, {(P-MW){1'b0}}};
    seed_prod = (P+XW)'(C32) * (P+XW)'(d_w);
    t_prod    = (P+XW)'(d_w) * (P+XW)'(x_q);
    x_prod    = (2*XW)'(x_q) * (2*XW)'(TWO - t_q);
    q_prod    = (NW+XW)'(n_q) * (NW+XW)'(x_q);
    rem       = $signed(RW'(n_q) << MW) - $signed(RW'(q_q) * RW'(my_q));
    rem_adj   = rem;
    mant      = q_q[MW:1];
    rnd_up    = q_q[0] & (sticky_q | mant[0]);
    mant_r    = (MW+1)'(mant) + (MW+1)'(rnd_up);
    exp_f     = exp_q + EW'(mant_r[MW]);

    unique case (state_q)
      S_IDLE: if (data_valid_i) begin
        sign_d = x_i[W-1] ^ y_i[W-1];
        my_d   = my_w;
        n_d    = lt ? {mx_w, 1'b0} : {1'b0, mx_w};
        exp_d  = EW'(xe) - EW'(ye) + EW'(BIAS) - EW'(lt);
        it_d   = '0;
        state_d = S_SPECIAL;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) kind_d = K_NAN;
        else if (y_zero && !x_inf)                                   kind_d = K_DBZ;
        else if (x_zero || y_inf)                                    kind_d = K_ZERO;
        else if (x_inf)                                              kind_d = K_INF;
        else state_d = S_SEED;
      end
      S_SPECIAL: begin
        {inv_d, dbz_d, ovf_d, unf_d} = '0;
        unique case (kind_q)
          K_NAN:  begin z_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}}; inv_d = 1'b1; end
          K_DBZ:  begin z_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}; dbz_d = 1'b1; end
          K_ZERO: z_d = {sign_q, {(W-1){1'b0}}};
          K_INF:  z_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          default: ;
        endcase
        state_d = S_DONE;
      end
      S_SEED: begin
        x_d     = C48 - XW'(seed_prod >> P);
        state_d = S_ITER_T;
      end
      S_ITER_T: begin
        t_d     = XW'(t_prod >> P);
        state_d = S_ITER_X;
      end
      S_ITER_X: begin
        x_d = XW'(x_prod >> P);
        if (it_q == IW'(ITERATIONS - 1)) begin
          it_d    = '0;
          state_d = S_QUOT;
        end else begin
          it_d    = it_q + 1'b1;
          state_d = S_ITER_T;
        end
      end
      S_QUOT: begin
        q_d     = QW'(q_prod >> P);
        state_d = S_REM;
      end
      // reciprocal error is below one quotient ulp, so one correction step suffices
      S_REM: begin
        if (rem[RW-1]) begin
          q_d     = q_q - 1'b1;
          rem_adj = rem + $signed(RW'(my_q));
        end else if (rem >= $signed(RW'(my_q))) begin
          q_d     = q_q + 1'b1;
          rem_adj = rem - $signed(RW'(my_q));
        end
        sticky_d = (rem_adj != '0);
        state_d  = S_ROUND;
      end
      S_ROUND: begin
        {inv_d, dbz_d, ovf_d, unf_d} = '0;
        if (exp_f >= EXP_MAX) begin
          z_d   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (exp_f[EW-1] || exp_f == '0) begin
          z_d   = {sign_q, {(W-1){1'b0}}};
          unf_d = 1'b1;
        end else begin
          z_d = {sign_q, exp_f[EXP_W-1:0], FRAC_W'(mant_r)};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!vld_q) vld_d = 1'b1;
        else if (data_ready_i) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      kind_q   <= K_NAN;
      it_q     <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      n_q      <= '0;
      my_q     <= '0;
      x_q      <= '0;
      t_q      <= '0;
      q_q      <= '0;
      sticky_q <= 1'b0;
      z_q      <= '0;
      inv_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      it_q     <= it_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      n_q      <= n_d;
      my_q     <= my_d;
      x_q      <= x_d;
      t_q      <= t_d;
      q_q      <= q_d;
      sticky_q <= sticky_d;
      z_q      <= z_d;
      inv_q    <= inv_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      vld_q    <= vld_d;
    end
  end

  assign ready_o                    = (state_q == S_IDLE);
  assign data_valid_o               = vld_q;
  assign z_o                        = z_q;
  assign except_invalid_operation_o = inv_q;
  assign except_div_by_zero_o       = dbz_q;
  assign except_overflow_o          = ovf_q;
  assign except_underflow_o         = unf_q;
endmodule

// File: tb/tb_fp_div_nr.sv
// Directed bench for fp_div_nr: single-precision instance plus a half-precision
// instance (EXP_W=5, FRAC_W=10, ITERATIONS=2).
module tb_fp_div_nr;
  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  logic        dv_i, rdy_o, dv_o, dr_i, inv, dbz, ovf, unf;
  logic [31:0] x_i, y_i, z_o;
  logic        hdv_i, hrdy_o, hdv_o, hdr_i, hinv, hdbz, hovf, hunf;
  logic [15:0] hx_i, hy_i, hz_o;

  int total = 0;
  int bad = 0;

  fp_div_nr dut (
    .clk_i(clk), .rst_ni(rst_ni), .data_valid_i(dv_i), .ready_o(rdy_o),
    .x_i(x_i), .y_i(y_i), .data_valid_o(dv_o), .data_ready_i(dr_i), .z_o(z_o),
    .except_invalid_operation_o(inv), .except_div_by_zero_o(dbz),
    .except_overflow_o(ovf), .except_underflow_o(unf));

  fp_div_nr #(.EXP_W(5), .FRAC_W(10), .ITERATIONS(2)) dut_h (
    .clk_i(clk), .rst_ni(rst_ni), .data_valid_i(hdv_i), .ready_o(hrdy_o),
    .x_i(hx_i), .y_i(hy_i), .data_valid_o(hdv_o), .data_ready_i(hdr_i), .z_o(hz_o),
    .except_invalid_operation_o(hinv), .except_div_by_zero_o(hdbz),
    .except_overflow_o(hovf), .except_underflow_o(hunf));

  // flags packed as {invalid, div_by_zero, overflow, underflow}
  localparam int NN = 9;
  localparam logic [31:0] NX [NN] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h7F7FFFFF,
    32'h00800000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40C00000};
  localparam logic [31:0] NY [NN] = '{32'h40400000, 32'h40400000, 32'h40400000, 32'h3F000000,
    32'h40000000, 32'h3F800000, 32'h3FC00000, 32'h40000000, 32'hC0400000};
  localparam logic [31:0] NZ [NN] = '{32'h40000000, 32'h3EAAAAAB, 32'hC0000000, 32'h7F800000,
    32'h00000000, 32'h3F800000, 32'h3FAAAAAB, 32'h3FC00000, 32'hC0000000};
  localparam logic [3:0]  NF [NN] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010,
    4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

  localparam int NS = 10;
  localparam logic [31:0] SX [NS] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7FC00001,
    32'hBF800000, 32'h00000000, 32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h00000001};
  localparam logic [31:0] SY [NS] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F800000,
    32'h00000000, 32'h40400000, 32'h7F800000, 32'h00000000, 32'h40000000, 32'h3F800000};
  localparam logic [31:0] SZ [NS] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
    32'hFF800000, 32'h00000000, 32'h00000000, 32'h7F800000, 32'hFF800000, 32'h00000000};
  localparam logic [3:0]  SF [NS] = '{4'b0100, 4'b1000, 4'b1000, 4'b1000,
    4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

  // Offers one operand pair, scrambles inputs after acceptance, waits (bounded) for the result.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] z, output logic [3:0] fl, output int lat);
    x_i = x; y_i = y; dv_i = 1'b1; dr_i = 1'b1;
    @(posedge clk); #1;
    dv_i = 1'b0; x_i = 32'hDEADBEEF; y_i = 32'h12345678;
    lat = 0;
    while (!dv_o && lat < 60) begin @(posedge clk); #1; lat++; end
    z = z_o; fl = {inv, dbz, ovf, unf};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if (rdy_o !== 1'b1 || hrdy_o !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b/%b want=1/1", rdy_o, hrdy_o);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({dv_o, z_o, inv, dbz, ovf, unf} !== '0 || {hdv_o, hz_o, hinv, hdbz, hovf, hunf} !== '0) begin
      bad++; $display("FAIL reset_outputs got z=%h dv=%b want z=0 dv=0 flags=0", z_o, dv_o);
    end
    rst_ni = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rdy_o !== 1'b1 || dv_o !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle got ready=%b dv=%b want 1/0", rdy_o, dv_o);
    end
  endtask

  task automatic test_normal();
    logic [31:0] z; logic [3:0] fl; int lat;
    for (int i = 0; i < NN; i++) begin
      run_op(NX[i], NY[i], z, fl, lat);
      total++;
      if (z !== NZ[i]) begin bad++; $display("FAIL normal_z[%0d] got=%h want=%h", i, z, NZ[i]); end
      total++;
      if (fl !== NF[i]) begin bad++; $display("FAIL normal_flags[%0d] got=%b want=%b", i, fl, NF[i]); end
      total++;
      if (lat != 11) begin bad++; $display("FAIL normal_latency[%0d] got=%0d want=11", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [31:0] z; logic [3:0] fl; int lat;
    for (int i = 0; i < NS; i++) begin
      run_op(SX[i], SY[i], z, fl, lat);
      total++;
      if (z !== SZ[i]) begin bad++; $display("FAIL special_z[%0d] got=%h want=%h", i, z, SZ[i]); end
      total++;
      if (fl !== SF[i]) begin bad++; $display("FAIL special_flags[%0d] got=%b want=%b", i, fl, SF[i]); end
      total++;
      if (lat != 2) begin bad++; $display("FAIL special_latency[%0d] got=%0d want=2", i, lat); end
    end
  endtask

  task automatic test_half();
    logic [15:0] hx [2] = '{16'h3C00, 16'h4600};
    logic [15:0] hz [2] = '{16'h3555, 16'h4000};
    int lat;
    for (int i = 0; i < 2; i++) begin
      hx_i = hx[i]; hy_i = 16'h4200; hdv_i = 1'b1; hdr_i = 1'b1;
      @(posedge clk); #1;
      hdv_i = 1'b0; hx_i = 16'hFFFF;
      lat = 0;
      while (!hdv_o && lat < 60) begin @(posedge clk); #1; lat++; end
      total++;
      if (hz_o !== hz[i] || {hinv, hdbz, hovf, hunf} !== 4'b0000) begin
        bad++; $display("FAIL half_z[%0d] got=%h flags=%b want=%h flags=0000", i, hz_o, {hinv, hdbz, hovf, hunf}, hz[i]);
      end
      total++;
      if (lat != 9) begin bad++; $display("FAIL half_latency[%0d] got=%0d want=9", i, lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    x_i = 32'h40C00000; y_i = 32'h40400000; dv_i = 1'b1; dr_i = 1'b1;
    @(posedge clk); #1;
    x_i = 32'h3F800000; y_i = 32'h00000000;
    lat = 0;
    repeat (3) begin
      total++;
      if (rdy_o !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", rdy_o); end
      @(posedge clk); #1; lat++;
    end
    dv_i = 1'b0;
    while (!dv_o && lat < 60) begin @(posedge clk); #1; lat++; end
    total++;
    if (z_o !== 32'h40000000 || dbz !== 1'b0 || lat != 11) begin
      bad++; $display("FAIL busy_ignore got z=%h dbz=%b lat=%0d want z=40000000 dbz=0 lat=11", z_o, dbz, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] zc;
    x_i = 32'h3F800000; y_i = 32'h40400000; dv_i = 1'b1; dr_i = 1'b0;
    @(posedge clk); #1;
    dv_i = 1'b0;
    lat = 0;
    while (!dv_o && lat < 60) begin @(posedge clk); #1; lat++; end
    zc = z_o;
    total++;
    if (zc !== 32'h3EAAAAAB) begin bad++; $display("FAIL bp_z got=%h want=3eaaaaab", zc); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({dv_o, rdy_o, z_o, inv, dbz, ovf, unf} !== {1'b1, 1'b0, 32'h3EAAAAAB, 4'b0000}) begin
        bad++; $display("FAIL bp_hold[%0d] got dv=%b rdy=%b z=%h want dv=1 rdy=0 z=3eaaaaab", i, dv_o, rdy_o, z_o);
      end
    end
    dr_i = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dv_o !== 1'b0 || rdy_o !== 1'b1) begin
      bad++; $display("FAIL bp_release got dv=%b rdy=%b want dv=0 rdy=1", dv_o, rdy_o);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] z; logic [3:0] fl; int lat; int seen;
    x_i = 32'h40C00000; y_i = 32'h40400000; dv_i = 1'b1; dr_i = 1'b1;
    @(posedge clk); #1;
    dv_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b0;
    #1;
    total++;
    if ({dv_o, z_o, inv, dbz, ovf, unf} !== '0 || rdy_o !== 1'b1) begin
      bad++; $display("FAIL midreset_clear got dv=%b z=%h rdy=%b want 0/0/1", dv_o, z_o, rdy_o);
    end
    @(posedge clk); #1 rst_ni = 1'b1;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (dv_o) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL midreset_no_valid got=%0d cycles want=0", seen); end
    run_op(32'h40C00000, 32'h40400000, z, fl, lat);
    total++;
    if (z !== 32'h40000000 || fl !== 4'b0000 || lat != 11) begin
      bad++; $display("FAIL midreset_after got z=%h fl=%b lat=%0d want 40000000/0000/11", z, fl, lat);
    end
  endtask

  initial begin
    dv_i = 1'b0; dr_i = 1'b1; x_i = '0; y_i = '0;
    hdv_i = 1'b0; hdr_i = 1'b1; hx_i = '0; hy_i = '0;
    test_reset();
    test_normal();
    test_special();
    test_half();
    test_busy_ignore();
    test_backpressure();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
